shift_reg_piso_tx: RTL
======================

Name: shift_reg_piso_tx

Overview:
Parallel-in, serial-out shift register: the transmit end for our serial-in/parallel-out shift registers. Accepts a WIDTH-bit word through a valid/ready load handshake and emits it MSB first, one bit per Clk rising edge. Flags every serial bit with Q_valid and pulses Done on the last bit of each frame. Supports back-to-back frames with no idle gap.

Parameters:
WIDTH, 4, data word width in bits (legal range 2..32).

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Rst_n  input  1  reset, asynchronous, active-low.
Din  input  WIDTH  parallel word to transmit.
Load_valid  input  1  Din is valid this cycle.
Load_ready  output  1  block can accept a word this cycle (combinational from state).
Q  output  1  serial data out, MSB first (registered).
Q_valid  output  1  Q carries a frame bit this cycle (registered).
Done  output  1  one-cycle pulse coincident with the final bit of a frame (registered).

Behaviour:
- Reset (Rst_n=0, asynchronous): state=IDLE, shift register=0, bit counter=0. Outputs Q=0, Q_valid=0, Done=0. Load_ready=1 once reset is released.
- States: IDLE and SHIFT.
- Accept rule: a word is accepted on any rising edge where Load_valid=1 and Load_ready=1.
- Load_ready = (state==IDLE) OR (state==SHIFT AND bit counter==0).
- IDLE:
  - Q=0, Q_valid=0.
  - On accept: capture Din, set counter=WIDTH-1, go to SHIFT.
- SHIFT:
  - Q = shift register MSB, Q_valid=1.
  - Each edge: shift left by one (LSB filled with 0) and decrement the counter.
- Latency: the first bit (Din[WIDTH-1]) appears on Q the cycle after accept. Bit k (MSB = k of 0) appears k+1 cycles after accept. A frame lasts WIDTH cycles.
- Last bit (counter==0):
  - Done=1 for that cycle only.
  - If an accept occurs at the same edge, reload Din and stay in SHIFT. The next frame's MSB follows the current LSB with no gap.
  - Otherwise return to IDLE.
- Load_valid while Load_ready=0 is ignored: no capture, no error. Din may change freely.
- Counter width is clog2(WIDTH). The counter never wraps below 0, because reload or IDLE always follows counter==0.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous). Q_valid and Done go to 0 with no Done pulse, and the partial frame is discarded.
- Simultaneous reset and accept: reset wins; the word is not captured.

Optional Feature:
Macro: SHIFT_REG_PARITY_EN.
- Defined: after the WIDTH data bits, one extra SHIFT cycle drives Q = XOR of the captured word (even parity), with Q_valid=1.
  - Frame length is WIDTH+1.
  - Counter loads WIDTH; its width becomes clog2(WIDTH+1).
  - Done and the back-to-back reload window move to the parity cycle.
- Not defined: no parity cycle or parity logic; behaviour exactly as above.

Decomposition:
- Package shift_reg_pkg holds:
  - the state typedef (enum logic {IDLE, SHIFT});
  - SHIFT_REG_DEFAULT_WIDTH = 4, shared with the serial-in shift registers.
- No sub-module. Counter, shift register and FSM stay in one always_ff plus one combinational Load_ready assign.

Test Plan:
1. Idle after reset, Load_valid=0 for 5 cycles -> Q=0, Q_valid=0, Done=0, Load_ready=1 throughout.
2. WIDTH=4, accept Din=4'b1011 -> next 4 cycles Q=1,0,1,1 with Q_valid=1; Done=1 only on the 4th; then IDLE with Q_valid=0.
3. Back-to-back: accept 4'b1011, hold Load_valid=1 with Din=4'b0110 -> Load_ready=1 only on the last-bit cycle. Q streams 1,0,1,1,0,1,1,0 over 8 contiguous Q_valid cycles; Done on cycles 4 and 8.
4. Load during busy: accept 4'b1100, pulse Load_valid with Din=4'b0011 on frame cycle 2 -> ignored; Q=1,1,0,0, then IDLE.
5. Reset mid-frame: accept 4'b1111, drop Rst_n between the 2nd and 3rd bits -> Q_valid and Q go to 0 immediately, no Done. After release, Load_ready=1 and accepting 4'b0101 yields 0,1,0,1.
6. With SHIFT_REG_PARITY_EN, accept 4'b1011 -> Q=1,0,1,1,1 (parity=1) over 5 valid cycles, Done on the 5th. Accepting 4'b1001 yields parity bit 0.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
// Shared definitions for the shift-register family (serial-in and
// parallel-in transmit variants).
//   state_e                 : two-state control encoding (IDLE / SHIFT)
//   SHIFT_REG_DEFAULT_WIDTH : default word width shared by the family
//   even_parity()           : XOR-reduce helper for the optional parity bit
// -----------------------------------------------------------------------------
package shift_reg_pkg;

   localparam int SHIFT_REG_DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Even parity of a word; narrower words are zero-extended by the caller,
   // which leaves the XOR result unchanged.
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_tx
// Parallel-in / serial-out transmitter. A WIDTH-bit word is accepted through
// a valid/ready handshake and shifted out MSB first, one bit per clock.
// Back-to-back frames are supported: a new word may be accepted on the final
// bit of the current frame so that its MSB follows without a gap.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Din        in   [WIDTH-1:0] parallel word
//   Load_valid in   Din is valid this cycle
//   Load_ready out  word can be accepted this cycle (decoded from state)
//   Q          out  serial data, MSB first (registered)
//   Q_valid    out  Q carries a frame bit (registered)
//   Done       out  one-cycle pulse on the final bit of a frame (registered)
//
// Build option
//   SHIFT_REG_PARITY_EN : appends an even-parity bit as an extra frame cycle
//                         (frame length WIDTH+1, Done on the parity cycle).
// -----------------------------------------------------------------------------
module shift_reg_piso_tx
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = SHIFT_REG_DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] Din,
   input  logic             Load_valid,
   output logic             Load_ready,
   output logic             Q,
   output logic             Q_valid,
   output logic             Done
);

`ifdef SHIFT_REG_PARITY_EN
   localparam int             CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
`else
   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
`endif

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               q_q, q_d;
   logic               q_valid_q, q_valid_d;
   logic               done_q, done_d;
   logic               accept_s;
   logic               last_s;
`ifdef SHIFT_REG_PARITY_EN
   logic               par_q, par_d;
`endif

   // Ready in IDLE, or on the last frame bit to allow a gapless reload.
   assign last_s     = (cnt_q == {CNT_W{1'b0}});
   assign Load_ready = (state_q == IDLE) || ((state_q == SHIFT) && last_s);
   assign accept_s   = Load_valid && Load_ready;

   // Next-state for FSM, shift register, counter and registered outputs.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
`ifdef SHIFT_REG_PARITY_EN
      par_d   = par_q;
`endif
      if (accept_s) begin
         state_d = SHIFT;
         sreg_d  = Din;
         cnt_d   = CNT_LOAD;
`ifdef SHIFT_REG_PARITY_EN
         par_d   = even_parity(32'(Din));
`endif
      end else begin
         case (state_q)
            SHIFT: begin
               sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
               if (last_s) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            IDLE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      // Outputs are computed from next state so they change with the state flops.
      q_valid_d = (state_d == SHIFT);
      done_d    = (state_d == SHIFT) && (cnt_d == {CNT_W{1'b0}});
      if (state_d == SHIFT) begin
`ifdef SHIFT_REG_PARITY_EN
         // Counter value zero is the trailing parity cycle.
         if (cnt_d == {CNT_W{1'b0}}) begin
            q_d = par_d;
         end else begin
            q_d = sreg_d[WIDTH-1];
         end
`else
         q_d = sreg_d[WIDTH-1];
`endif
      end else begin
         q_d = 1'b0;
      end
   end

   // State and output registers with asynchronous abort of any frame.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         sreg_q    <= {WIDTH{1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
         q_q       <= 1'b0;
         q_valid_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         done_q    <= done_d;
`ifdef SHIFT_REG_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign Q       = q_q;
   assign Q_valid = q_valid_q;
   assign Done    = done_q;

endmodule
